ps2_key_decoder: RTL and testbench

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_key_decoder.sv | 228 ++++++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and key decoder.
// Synchronizes and de-glitches the keyboard clock, deframes 11-bit PS/2
// frames, tracks E0/F0 prefixes and turns make/break codes into held key
// levels plus the most recently pressed scan code.
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       scan_ext,
  output logic       key_valid,
  output logic       key_left,
  output logic       key_right,
  output logic       key_down,
  output logic       key_rotate,
  output logic       key_drop,
  output logic       key_hold,
  output logic       code_strobe,
  output logic       frame_err
);

  localparam int FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // One-hot key position: bit 0 left, 1 right, 2 down, 3 rotate, 4 drop, 5 hold.
  // The prefix state is part of the lookup so E0 12 and bare 6B map to nothing.
  function automatic logic [5:0] key_mask(input logic [7:0] code, input logic ext);
    key_mask = 6'b000000;
    case ({ext, code})
      9'h16B:  key_mask = 6'b000001;
      9'h174:  key_mask = 6'b000010;
      9'h172:  key_mask = 6'b000100;
      9'h175:  key_mask = 6'b001000;
      9'h029:  key_mask = 6'b010000;
      9'h012:  key_mask = 6'b100000;
      default: key_mask = 6'b000000;
    endcase
  endfunction

  // Keyboard replies to host commands (ACK, BAT pass, echo, resend, errors).
  function automatic logic is_response(input logic [7:0] code);
    is_response = (code == 8'h00) || (code == 8'hAA) || (code == 8'hEE) ||
                  (code == 8'hFA) || (code == 8'hFE) || (code == 8'hFF);
  endfunction

  // ---- stage p0: two-flop synchronizers (idle lines are high) ----
  logic [1:0] clk_sync_p0;
  logic [1:0] dat_sync_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_p0 <= 2'b11;
      dat_sync_p0 <= 2'b11;
    end else begin
      clk_sync_p0 <= {clk_sync_p0[0], ps2_clk};
      dat_sync_p0 <= {dat_sync_p0[0], ps2_data};
    end
  end

  // ---- stage p1: clock filter; vld_p1 marks a filtered falling edge ----
  logic [FLT_W-1:0] flt_cnt;
  logic             clk_flt_p1;
  logic             vld_p1;
  logic             dat_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt_cnt    <= '0;
      clk_flt_p1 <= 1'b1;
      vld_p1     <= 1'b0;
      dat_p1     <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (clk_sync_p0[1] == clk_flt_p1) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
        flt_cnt    <= '0;
        clk_flt_p1 <= clk_sync_p0[1];
        vld_p1     <= ~clk_sync_p0[1];
        dat_p1     <= dat_sync_p0[1];
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  // ---- stage p2: frame FSM, shift register and inactivity timeout ----
  state_t          state, state_nxt;
  logic [2:0]      bit_cnt_p2;
  logic [7:0]      shreg_p2;
  logic            par_p2;
  logic [TO_W-1:0] to_cnt_p2;
  logic            byte_ok_p2;
  logic            frm_err_p2;
  logic            timeout_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    byte_ok_p2 = 1'b0;
    frm_err_p2 = 1'b0;
    // An edge arriving on the expiry cycle wins: it proves the device is alive.
    timeout_p2 = (state != ST_IDLE) && !vld_p1 &&
                 (to_cnt_p2 == TO_W'(TIMEOUT_CYCLES - 1));
    case (state)
      ST_IDLE: begin
        if (vld_p1 && !dat_p1) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (vld_p1 && (bit_cnt_p2 == 3'd7)) state_nxt = ST_PARITY;
      end
      ST_PARITY: begin
        if (vld_p1) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (vld_p1) begin
          state_nxt = ST_IDLE;
          if (dat_p1 && (^{shreg_p2, par_p2})) byte_ok_p2 = 1'b1;
          else                                 frm_err_p2 = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (timeout_p2) begin
      state_nxt  = ST_IDLE;
      frm_err_p2 = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_p2 <= '0;
      shreg_p2   <= '0;
      par_p2     <= 1'b0;
      to_cnt_p2  <= '0;
    end else begin
      if (state == ST_IDLE || vld_p1) to_cnt_p2 <= '0;
      else                            to_cnt_p2 <= to_cnt_p2 + 1'b1;

      if (state == ST_IDLE) begin
        bit_cnt_p2 <= '0;
      end else if (vld_p1 && state == ST_DATA) begin
        shreg_p2   <= {dat_p1, shreg_p2[7:1]};
        bit_cnt_p2 <= bit_cnt_p2 + 1'b1;
      end else if (vld_p1 && state == ST_PARITY) begin
        par_p2 <= dat_p1;
      end
    end
  end

  // ---- stage p3: prefix tracking and registered key outputs ----
  logic       ext_flag;
  logic       brk_flag;
  logic [5:0] keys_q;
  logic [5:0] hit_mask;

  assign hit_mask = key_mask(shreg_p2, ext_flag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_flag    <= 1'b0;
      brk_flag    <= 1'b0;
      keys_q      <= '0;
      scan_code   <= '0;
      scan_ext    <= 1'b0;
      key_valid   <= 1'b0;
      code_strobe <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      code_strobe <= 1'b0;
      frame_err   <= frm_err_p2;
      if (frm_err_p2) begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end else if (byte_ok_p2) begin
        if (shreg_p2 == CODE_EXT) begin
          ext_flag <= 1'b1;
        end else if (shreg_p2 == CODE_BRK) begin
          brk_flag <= 1'b1;
        end else if (!ext_flag && !brk_flag && is_response(shreg_p2)) begin
          ext_flag <= 1'b0;
        end else begin
          code_strobe <= 1'b1;
          ext_flag    <= 1'b0;
          brk_flag    <= 1'b0;
          if (!brk_flag) begin
            keys_q    <= keys_q | hit_mask;
            scan_code <= shreg_p2;
            scan_ext  <= ext_flag;
            key_valid <= 1'b1;
          end else begin
            keys_q <= keys_q & ~hit_mask;
            if (shreg_p2 == scan_code && ext_flag == scan_ext) key_valid <= 1'b0;
          end
        end
      end
    end
  end

  assign key_left   = keys_q[0];
  assign key_right  = keys_q[1];
  assign key_down   = keys_q[2];
  assign key_rotate = keys_q[3];
  assign key_drop   = keys_q[4];
  assign key_hold   = keys_q[5];

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed key sequences plus random frames,
// compared every cycle against a byte-level reference model.
module tb_ps2_key_decoder;

  localparam int TO   = 2000;
  localparam int HALF = 20;
  localparam int WIN  = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scan_code;
  logic       scan_ext, key_valid;
  logic       key_left, key_right, key_down, key_rotate, key_drop, key_hold;
  logic       code_strobe, frame_err;

  ps2_key_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .scan_code(scan_code), .scan_ext(scan_ext), .key_valid(key_valid),
    .key_left(key_left), .key_right(key_right), .key_down(key_down),
    .key_rotate(key_rotate), .key_drop(key_drop), .key_hold(key_hold),
    .code_strobe(code_strobe), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // reference model state
  logic [7:0] km_code [6] = '{8'h6B, 8'h74, 8'h72, 8'h75, 8'h29, 8'h12};
  bit         km_ext  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  bit         m_ext, m_brk, m_sext, m_valid;
  logic [7:0] m_code;
  logic [5:0] m_keys;
  int         exp_str, exp_err;
  int         cyc = 0;
  int         mask_until = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [15:0] dut_levels();
    return {scan_code, scan_ext, key_valid,
            key_hold, key_drop, key_rotate, key_down, key_right, key_left};
  endfunction

  function automatic logic [15:0] mdl_levels();
    return {m_code, m_sext, m_valid, m_keys};
  endfunction

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_sext = 0; m_valid = 0; m_code = 8'h00; m_keys = '0;
  endtask

  // Apply one complete received byte to the model (bad = frame error).
  task automatic model_byte(input logic [7:0] b, input bit bad);
    int idx;
    exp_str = 0; exp_err = 0;
    idx = -1;
    for (int k = 0; k < 6; k++)
      if (km_code[k] == b && km_ext[k] == m_ext) idx = k;
    if (bad) begin
      exp_err = 1; m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (!m_ext && !m_brk && (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF})) begin
      exp_str = 0;
    end else begin
      exp_str = 1;
      if (!m_brk) begin
        m_code = b; m_sext = m_ext; m_valid = 1;
        if (idx >= 0) m_keys[idx] = 1'b1;
      end else begin
        if (idx >= 0) m_keys[idx] = 1'b0;
        if (b == m_code && m_ext == m_sext) m_valid = 0;
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Send start + nbits data bits; nbits >= 8 sends a whole frame, fewer
  // abandons the frame and waits out the inactivity timeout.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] f;
    int last;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    last = (nbits >= 8) ? 10 : nbits;
    for (int i = 0; i <= last; i++) begin
      ps2_data = f[i];
      tick(HALF);
      ps2_clk = 1'b0;
      if (i == 10) begin
        model_byte(b, bad_par);
        mask_until = cyc + WIN;
      end else if (i == last) begin
        exp_str = 0; exp_err = 1; m_ext = 0; m_brk = 0;
        mask_until = cyc + TO + 60;
      end
      tick(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    if (nbits < 8) tick(TO + 80);
    else           tick(HALF);
  endtask

  // Per-cycle comparison against the model; around each model update a
  // short window lets the DUT latency settle while pulses are counted.
  initial begin : compare
    int seen_str, seen_err;
    seen_str = 0; seen_err = 0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (cyc < mask_until) begin
          seen_str += int'(code_strobe);
          seen_err += int'(frame_err);
        end else if (cyc == mask_until) begin
          seen_str += int'(code_strobe);
          seen_err += int'(frame_err);
          check("strobe_pulses", seen_str, exp_str);
          check("err_pulses", seen_err, exp_err);
          check("levels_after_byte", dut_levels(), mdl_levels());
          seen_str = 0; seen_err = 0;
        end else begin
          check("levels", dut_levels(), mdl_levels());
          check("pulses_quiet", {code_strobe, frame_err}, 2'b00);
        end
      end
      cyc++;
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    logic [7:0] rb;
    bit         rbad;
    rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    model_reset();
    tick(3);
    check("reset_outputs", {dut_levels(), code_strobe, frame_err}, 18'h0);
    rst_n = 1'b1;
    tick(5);

    // make / break of drop
    send_frame(8'h29, 0, 8);
    check("drop_make", key_drop, 1'b1);
    check("drop_code", scan_code, 8'h29);
    check("drop_valid", key_valid, 1'b1);
    send_frame(8'hF0, 0, 8);
    send_frame(8'h29, 0, 8);
    check("drop_break", key_drop, 1'b0);
    check("drop_valid_clr", key_valid, 1'b0);
    check("drop_code_hold", scan_code, 8'h29);

    // left + hold, then release left
    send_frame(8'hE0, 0, 8); send_frame(8'h6B, 0, 8);
    send_frame(8'h12, 0, 8);
    check("left_and_hold", {key_left, key_hold}, 2'b11);
    send_frame(8'hE0, 0, 8); send_frame(8'hF0, 0, 8); send_frame(8'h6B, 0, 8);
    check("left_rel", {key_left, key_hold}, 2'b01);
    check("hold_code", scan_code, 8'h12);
    check("hold_valid", key_valid, 1'b1);

    // parity error drops the pending E0
    send_frame(8'hE0, 0, 8);
    send_frame(8'h74, 1, 8);
    check("par_err_right", key_right, 1'b0);
    send_frame(8'h74, 0, 8);
    check("noext_right", key_right, 1'b0);
    check("noext_code", {scan_code, scan_ext}, 9'h0E8);

    // timeout drops the pending F0
    send_frame(8'hF0, 0, 8);
    send_frame(8'h5A, 0, 5);
    send_frame(8'hE0, 0, 8); send_frame(8'h75, 0, 8);
    check("rotate_make", key_rotate, 1'b1);
    check("rotate_ext", {scan_code, scan_ext}, 9'h0EB);

    // response bytes and E0 12
    send_frame(8'hF0, 0, 8); send_frame(8'h12, 0, 8);
    check("hold_rel", key_hold, 1'b0);
    send_frame(8'hAA, 0, 8);
    send_frame(8'hE0, 0, 8); send_frame(8'h12, 0, 8);
    check("e0_12_hold", key_hold, 1'b0);
    check("e0_12_code", {scan_code, scan_ext}, 9'h025);

    // short clock glitches while idle, data low
    ps2_data = 1'b0;
    repeat (3) begin
      ps2_clk = 1'b0; tick(2); ps2_clk = 1'b1; tick(30);
    end
    ps2_data = 1'b1;
    tick(TO + 100);

    // a real falling edge with data high is not a start bit
    ps2_clk = 1'b0; tick(HALF); ps2_clk = 1'b1;
    tick(TO + 100);

    // random traffic
    for (int n = 0; n < 50; n++) begin
      case ($urandom_range(0, 11))
        0: rb = 8'h29;  1: rb = 8'h12;  2: rb = 8'h6B;  3: rb = 8'h74;
        4: rb = 8'h72;  5: rb = 8'h75;  6: rb = 8'hE0;  7: rb = 8'hF0;
        8: rb = 8'hF0;  9: rb = 8'hAA; 10: rb = 8'hFA;
        default: rb = 8'($urandom_range(0, 255));
      endcase
      rbad = ($urandom_range(0, 7) == 0);
      send_frame(rb, rbad, 8);
    end

    // reset in the middle of a frame
    send_frame(8'h29, 0, 8);
    ps2_data = 1'b0; tick(HALF); ps2_clk = 1'b0; tick(HALF); ps2_clk = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ps2_data = i[0]; tick(HALF); ps2_clk = 1'b0; tick(HALF); ps2_clk = 1'b1;
    end
    tick(HALF / 2);
    rst_n = 1'b0;
    #1;
    check("async_reset", {dut_levels(), code_strobe, frame_err}, 18'h0);
    model_reset();
    ps2_data = 1'b1; ps2_clk = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(5);
    send_frame(8'h29, 0, 8);
    check("post_reset_drop", {key_drop, scan_code}, 9'h129);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
